fft64: RTL and testbench
========================

FFT64 -- requirements
Module: fft64

Interface
REQ-001 Parameter TWF, default 10, fractional bits of the signed cos/sin twiddle constants (Q1.TWF).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 valid_a  input  1  input sample valid strobe.
REQ-005 ar  input  11  signed real part of input sample, two's complement.
REQ-006 ai  input  11  signed imaginary part of input sample.
REQ-007 valid_o  output  1  output bin valid strobe, registered.
REQ-008 xr  output  11  signed real part of output bin, registered.
REQ-009 xi  output  11  signed imaginary part of output bin, registered.

Function
REQ-010 Block SHALL compute an unscaled 64-point forward DFT: X[k] = sum over n=0..63 of x[n]·exp(-j2πnk/64).
- No 1/N scaling.
- Inverse transform and 1/64 scaling belong to ifft64.
REQ-011 A frame SHALL be the first 64 samples captured on cycles with valid_a=1 while idle, in natural order n=0..63.
- Gaps (valid_a=0) inside a frame SHALL be allowed.
- Gap cycles SHALL not be captured.
REQ-012 After the 64th sample the block SHALL go busy and compute (radix-2 or equivalent, internal datapath ≥18 bits).
REQ-013 valid_a SHALL be ignored while busy or outputting.
REQ-014 States SHALL be IDLE/LOAD → COMPUTE → OUTPUT → IDLE.
- LOAD → COMPUTE on the 64th captured sample.
- COMPUTE → OUTPUT when all butterflies are done.
- OUTPUT → IDLE after bin 63 is emitted.
REQ-015 First valid_o SHALL rise a fixed number of cycles (≤256) after the 64th input sample.
- Bins k=0..63 SHALL follow in natural order on 64 consecutive cycles with valid_o=1.
- valid_o SHALL then drop to 0.
REQ-016 While valid_o=0, xr and xi SHALL be driven to 0.
REQ-017 Final results SHALL be rounded to nearest integer, half away from zero.
REQ-018 Accuracy: for |ar|,|ai| ≤ 15, each output component SHALL be within ±3 of the exactly rounded DFT.
REQ-019 A new frame SHALL be accepted starting the cycle after the last output bin, with no dead cycle.

Reset
REQ-020 RST=1 SHALL immediately clear valid_o, xr and xi to 0, return the FSM to IDLE and clear the sample counter, regardless of CLK.
REQ-021 RST asserted mid-frame or mid-output SHALL discard the partial frame.
- No valid_o pulses SHALL occur until a complete new frame is captured after RST falls.
REQ-022 Sample buffer contents need not be cleared by reset.

Configuration
REQ-023 Macro FFT64_SATURATE_EN, when defined: output components outside [-1024,1023] SHALL clamp to -1024 or 1023.
REQ-024 Without FFT64_SATURATE_EN: outputs SHALL be the low 11 bits of the rounded result (two's-complement wrap).
REQ-025 In-range results SHALL be identical with and without FFT64_SATURATE_EN.

Verification
REQ-026 Impulse: x[0]=(1,0), others 0 -> all 64 bins (1,0) ±0.
REQ-027 DC: all 64 samples (1,0) -> X[0]=(64,0); X[1..63]=(0,0) ±1.
REQ-028 Random frame, 64 samples uniformly in [-15,15] -> each bin matches double-precision DFT ±3.
- Repeat with 10 random valid_a gaps: results SHALL be identical.
REQ-029 Reset mid-frame: RST pulse after 30 samples, then a full DC frame -> exactly 64 valid_o cycles, X[0]=(64,0).
REQ-030 Overflow: all samples (20,0) -> X[0] = (1023,0) with FFT64_SATURATE_EN; (-768,0) without.
REQ-031 Back-to-back: frame B's valid_a starts the cycle after frame A's bin 63 -> both frames correct, same latency.

Source files
------------

// File: rtl/fft64.sv
// fft64 -- 64-point unscaled forward DFT, radix-2 decimation in time.
//
// Samples are written into a register array in bit-reversed order while the
// frame is captured. Six in-place butterfly stages then run at one butterfly
// per clock (192 cycles). The 64 bins are finally streamed out in natural
// order through registered outputs.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   valid_a  in   input sample strobe (ignored while computing/outputting)
//   ar, ai   in   11-bit signed input sample (real / imaginary)
//   valid_o  out  output bin strobe (registered)
//   xr, xi   out  11-bit signed output bin, zero while valid_o=0 (registered)
//
// Parameter TWF: fractional bits of the Q1.TWF twiddle constants. The built-in
// table holds 10 fractional bits, so values above 10 add no extra precision.
//
// Optional macro FFT64_SATURATE_EN: clamp out-of-range bins to [-1024,1023]
// instead of wrapping to the low 11 bits.
module fft64 #(
    parameter int TWF = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               valid_a,
    input  logic signed [10:0] ar,
    input  logic signed [10:0] ai,
    output logic               valid_o,
    output logic signed [10:0] xr,
    output logic signed [10:0] xi
);

    localparam int FB = 6;                  // internal fractional bits
    localparam int W  = 26;                 // internal datapath width
    localparam int TW = TWF + 2;            // twiddle width (holds +/-1.0)
    localparam int PW = W + TW;             // product width
    localparam int UP = (TWF >= 10) ? TWF - 10 : 0;
    localparam int DN = (TWF < 10) ? 10 - TWF : 0;
    localparam logic signed [TWF+12:0] TRND  = (TWF+13)'((2 ** DN) / 2);
    localparam logic signed [PW-1:0]   PHALF = PW'((2 ** TWF) / 2);
    localparam logic signed [W-1:0]    OHALF = W'((2 ** FB) / 2);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2:0]         stage_q, stage_d;
    logic               valid_o_q, valid_o_d;
    logic signed [10:0] xr_q, xr_d, xi_q, xi_d;

    logic signed [W-1:0] mem_re_q [0:63];
    logic signed [W-1:0] mem_im_q [0:63];

    logic                ld_we_s, bf_we_s;
    logic [5:0]          half_s, m1_s, m2_s, top_s, bot_s;
    logic [4:0]          twi_s;
    logic signed [TW-1:0] wc_s, ws_s;
    logic signed [W-1:0] a_re_s, a_im_s, b_re_s, b_im_s, t_re_s, t_im_s;
    logic signed [PW-1:0] acc_re_s, acc_im_s;

    // cos(2*pi*m/64) in Q1.10 for m = 0..16
    function automatic logic signed [11:0] qcos(input logic [4:0] m);
        case (m)
            5'd0:    qcos = 12'sd1024;
            5'd1:    qcos = 12'sd1019;
            5'd2:    qcos = 12'sd1004;
            5'd3:    qcos = 12'sd980;
            5'd4:    qcos = 12'sd946;
            5'd5:    qcos = 12'sd903;
            5'd6:    qcos = 12'sd851;
            5'd7:    qcos = 12'sd792;
            5'd8:    qcos = 12'sd724;
            5'd9:    qcos = 12'sd650;
            5'd10:   qcos = 12'sd569;
            5'd11:   qcos = 12'sd483;
            5'd12:   qcos = 12'sd392;
            5'd13:   qcos = 12'sd297;
            5'd14:   qcos = 12'sd200;
            5'd15:   qcos = 12'sd100;
            default: qcos = 12'sd0;
        endcase
    endfunction

    // cos(2*pi*m/64) for m = 0..31; second quadrant mirrors the first
    function automatic logic signed [11:0] cos_base(input logic [4:0] m);
        if (m <= 5'd16) cos_base = qcos(m);
        else            cos_base = -qcos(5'd0 - m);
    endfunction

    // sin(2*pi*m/64) for m = 0..31 (always >= 0 on this half circle)
    function automatic logic signed [11:0] sin_base(input logic [4:0] m);
        if (m <= 5'd16) sin_base = qcos(5'd16 - m);
        else            sin_base = qcos(m - 5'd16);
    endfunction

    // Rescale a Q1.10 table entry to Q1.TWF with rounding
    function automatic logic signed [TW-1:0] scale_tw(input logic signed [11:0] b);
        logic signed [TWF+12:0] e;
        e = (TWF+13)'(b);
        e = ((e <<< UP) + TRND) >>> DN;
        return e[TW-1:0];
    endfunction

    function automatic logic [5:0] bitrev(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    // Round half away from zero to an integer, then wrap or clamp to 11 bits
    function automatic logic signed [10:0] fmt_out(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        r = v + OHALF - W'(v[W-1]);
        r = r >>> FB;
`ifdef FFT64_SATURATE_EN
        if (r > W'(1023))       return 11'sd1023;
        else if (r < W'(-1024)) return 11'sh400;
        else                    return r[10:0];
`else
        return r[10:0];
`endif
    endfunction

    // Butterfly addressing and arithmetic for the current (stage, index)
    always_comb begin
        half_s   = 6'd1 << stage_q;
        m1_s     = half_s - 6'd1;
        // At stage 5 the shift wraps to 0, giving the all-ones mask needed
        m2_s     = (half_s << 1) - 6'd1;
        top_s    = ({cnt_q[4:0], 1'b0} & ~m2_s) | ({1'b0, cnt_q[4:0]} & m1_s);
        bot_s    = top_s | half_s;
        twi_s    = (cnt_q[4:0] & m1_s[4:0]) << (3'd5 - stage_q);
        wc_s     = scale_tw(cos_base(twi_s));
        ws_s     = scale_tw(sin_base(twi_s));
        a_re_s   = mem_re_q[top_s];
        a_im_s   = mem_im_q[top_s];
        b_re_s   = mem_re_q[bot_s];
        b_im_s   = mem_im_q[bot_s];
        // b * (cos - j sin)
        acc_re_s = PW'(b_re_s) * PW'(wc_s) + PW'(b_im_s) * PW'(ws_s) + PHALF;
        acc_im_s = PW'(b_im_s) * PW'(wc_s) - PW'(b_re_s) * PW'(ws_s) + PHALF;
        t_re_s   = W'(acc_re_s >>> TWF);
        t_im_s   = W'(acc_im_s >>> TWF);
    end

    // FSM next state, counters, write enables and next output values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        valid_o_d = 1'b0;
        xr_d      = 11'sd0;
        xi_d      = 11'sd0;
        ld_we_s   = 1'b0;
        bf_we_s   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (valid_a) begin
                    ld_we_s = 1'b1;
                    if (cnt_q == 6'd63) begin
                        state_d = S_COMPUTE;
                        cnt_d   = 6'd0;
                        stage_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_COMPUTE: begin
                bf_we_s = 1'b1;
                if (cnt_q == 6'd31) begin
                    cnt_d = 6'd0;
                    if (stage_q == 3'd5) begin
                        state_d = S_OUTPUT;
                        stage_d = 3'd0;
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_OUTPUT: begin
                valid_o_d = 1'b1;
                xr_d      = fmt_out(mem_re_q[cnt_q]);
                xi_d      = fmt_out(mem_im_q[cnt_q]);
                if (cnt_q == 6'd63) begin
                    state_d = S_LOAD;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = 6'd0;
                stage_d = 3'd0;
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_LOAD;
            cnt_q     <= 6'd0;
            stage_q   <= 3'd0;
            valid_o_q <= 1'b0;
            xr_q      <= 11'sd0;
            xi_q      <= 11'sd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stage_q   <= stage_d;
            valid_o_q <= valid_o_d;
            xr_q      <= xr_d;
            xi_q      <= xi_d;
        end
    end

    // Sample buffer: bit-reversed capture, then in-place butterflies
    always_ff @(posedge CLK) begin
        if (ld_we_s) begin
            mem_re_q[bitrev(cnt_q)] <= W'(ar) <<< FB;
            mem_im_q[bitrev(cnt_q)] <= W'(ai) <<< FB;
        end else if (bf_we_s) begin
            mem_re_q[top_s] <= a_re_s + t_re_s;
            mem_im_q[top_s] <= a_im_s + t_im_s;
            mem_re_q[bot_s] <= a_re_s - t_re_s;
            mem_im_q[bot_s] <= a_im_s - t_im_s;
        end
    end

    assign valid_o = valid_o_q;
    assign xr      = xr_q;
    assign xi      = xi_q;

endmodule

// File: tb/tb_fft64.sv
// Testbench for fft64: directed frames (impulse, DC, random, gaps,
// back-to-back, overflow, resets) checked against a double-precision DFT.
module tb_fft64;

    localparam real PI = 3.14159265358979323846;
`ifdef FFT64_SATURATE_EN
    localparam int OVF_X0 = 1023;
`else
    localparam int OVF_X0 = -768;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_a;
    logic signed [10:0] ar, ai;
    logic               valid_o;
    logic signed [10:0] xr, xi;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int cap_cyc = 0;
    int first_lat = -1;
    int in_r[64], in_i[64], got_r[64], got_i[64], save_r[64], save_i[64];

    fft64 #(.TWF(10)) dut (
        .CLK    (clk),
        .RST    (rst),
        .valid_a(valid_a),
        .ar     (ar),
        .ai     (ai),
        .valid_o(valid_o),
        .xr     (xr),
        .xi     (xi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fmt11(input int v);
`ifdef FFT64_SATURATE_EN
        if (v > 1023) return 1023;
        if (v < -1024) return -1024;
        return v;
`else
        int w;
        w = v & 2047;
        if (w >= 1024) w = w - 2048;
        return w;
`endif
    endfunction

    function automatic int rnd_hafz(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        else return -int'($floor(-x + 0.5));
    endfunction

    task automatic chk(input string tag, input int idx, input int obs, input int exp_v, input int tol);
        tests++;
        assert ((obs - exp_v <= tol) && (exp_v - obs <= tol))
        else begin
            failed++;
            $error("FAIL %s[%0d]: got %0d expected %0d (tol %0d)", tag, idx, obs, exp_v, tol);
        end
    endtask

    task automatic fill_const(input int re);
        for (int n = 0; n < 64; n++) begin
            in_r[n] = re;
            in_i[n] = 0;
        end
    endtask

    task automatic fill_rand();
        for (int n = 0; n < 64; n++) begin
            in_r[n] = int'($urandom_range(30, 0)) - 15;
            in_i[n] = int'($urandom_range(30, 0)) - 15;
        end
    endtask

    // Drives nsamp samples from the current negedge, with ngaps idle cycles
    // scattered inside the frame.
    task automatic send_frame(input int nsamp, input int ngaps);
        int gap_before[64];
        for (int i = 0; i < 64; i++) gap_before[i] = 0;
        for (int g = 0; g < ngaps; g++) gap_before[$urandom_range(63, 1)]++;
        for (int n = 0; n < nsamp; n++) begin
            for (int g = 0; g < gap_before[n]; g++) begin
                valid_a = 1'b0;
                ar = 11'($urandom);
                ai = 11'($urandom);
                @(negedge clk);
            end
            valid_a = 1'b1;
            ar = 11'(in_r[n]);
            ai = 11'(in_i[n]);
            @(negedge clk);
        end
        valid_a = 1'b0;
        cap_cyc = cyc;
    endtask

    // Waits for the output burst, collects 64 bins, ends on the negedge
    // following bin 63. With junk=1, random strobes are driven while busy.
    task automatic get_frame(input bit junk);
        int t;
        int lat;
        t = 0;
        while (valid_o !== 1'b1 && t < 400) begin
            if (junk) begin
                valid_a = 1'($urandom_range(1, 0));
                ar = 11'($urandom);
                ai = 11'($urandom);
            end
            @(negedge clk);
            t++;
        end
        valid_a = 1'b0;
        chk("out_timeout", 0, (t < 400) ? 1 : 0, 1, 0);
        lat = cyc - cap_cyc;
        if (first_lat < 0) begin
            first_lat = lat;
            chk("latency_le_256", 0, (lat <= 256) ? 1 : 0, 1, 0);
        end else begin
            chk("latency_same", 0, lat, first_lat, 0);
        end
        for (int k = 0; k < 64; k++) begin
            chk("valid_o_burst", k, int'(valid_o), 1, 0);
            got_r[k] = int'(xr);
            got_i[k] = int'(xi);
            @(negedge clk);
        end
        chk("valid_o_drop", 0, int'(valid_o), 0, 0);
        chk("xr_idle_zero", 0, int'(xr), 0, 0);
        chk("xi_idle_zero", 0, int'(xi), 0, 0);
    endtask

    task automatic check_ref(input string tag, input int tol0, input int tol);
        for (int k = 0; k < 64; k++) begin
            real re, im, ang;
            re = 0.0;
            im = 0.0;
            for (int n = 0; n < 64; n++) begin
                ang = -2.0 * PI * real'(n * k) / 64.0;
                re = re + real'(in_r[n]) * $cos(ang) - real'(in_i[n]) * $sin(ang);
                im = im + real'(in_r[n]) * $sin(ang) + real'(in_i[n]) * $cos(ang);
            end
            chk({tag, "_re"}, k, got_r[k], fmt11(rnd_hafz(re)), (k == 0) ? tol0 : tol);
            chk({tag, "_im"}, k, got_i[k], fmt11(rnd_hafz(im)), (k == 0) ? tol0 : tol);
        end
    endtask

    initial begin
        int t;
        int highs;
        rst = 1'b1;
        valid_a = 1'b0;
        ar = 11'sd0;
        ai = 11'sd0;
        repeat (3) @(negedge clk);
        chk("reset_valid_o", 0, int'(valid_o), 0, 0);
        chk("reset_xr", 0, int'(xr), 0, 0);
        chk("reset_xi", 0, int'(xi), 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Impulse: every bin exactly (1,0)
        fill_const(0);
        in_r[0] = 1;
        send_frame(64, 0);
        get_frame(1'b1);
        check_ref("impulse", 0, 0);

        // DC: X[0]=(64,0) exact, others within 1
        fill_const(1);
        send_frame(64, 0);
        get_frame(1'b1);
        check_ref("dc", 0, 1);

        // Random frame, then the same frame with gaps must match bit for bit
        fill_rand();
        send_frame(64, 0);
        get_frame(1'b0);
        check_ref("rand", 3, 3);
        for (int k = 0; k < 64; k++) begin
            save_r[k] = got_r[k];
            save_i[k] = got_i[k];
        end
        send_frame(64, 10);
        get_frame(1'b1);
        for (int k = 0; k < 64; k++) begin
            chk("gaps_same_re", k, got_r[k], save_r[k], 0);
            chk("gaps_same_im", k, got_i[k], save_i[k], 0);
        end

        // Back-to-back: next frame starts the cycle after bin 63
        fill_rand();
        send_frame(64, 0);
        get_frame(1'b0);
        check_ref("b2b", 3, 3);

        // Overflow of X[0]
        fill_const(20);
        send_frame(64, 0);
        get_frame(1'b1);
        chk("ovf_x0_re", 0, got_r[0], OVF_X0, 0);
        check_ref("ovf", 0, 1);

        // Reset after 30 samples discards the partial frame
        fill_rand();
        send_frame(30, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fill_const(1);
        send_frame(64, 0);
        get_frame(1'b0);
        check_ref("rst_mid_frame", 0, 1);

        // Reset during output clears outputs immediately, no clock needed
        fill_const(0);
        in_r[0] = 1;
        send_frame(64, 0);
        t = 0;
        while (valid_o !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("rst_out_timeout", 0, (t < 400) ? 1 : 0, 1, 0);
        repeat (5) @(negedge clk);
        chk("pre_rst_xr", 0, int'(xr), 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid_o", 0, int'(valid_o), 0, 0);
        chk("async_rst_xr", 0, int'(xr), 0, 0);
        chk("async_rst_xi", 0, int'(xi), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        highs = 0;
        repeat (300) begin
            @(negedge clk);
            if (valid_o !== 1'b0) highs++;
        end
        chk("no_valid_after_rst", 0, highs, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
